// File: rtl/sfx_sample_sequencer_if.sv
// Bus between the sound sequencer and its driver: game triggers and sample
// requests in, mixed PCM sample and status out.
interface sfx_sample_sequencer_if #(
    parameter int WIDTH = 16
);
    logic                    trig_shot;
    logic                    trig_hit;
    logic                    trig_march;
    logic [1:0]              march_sel;
    logic                    mute;
    logic                    sample_req;
    logic signed [WIDTH-1:0] sample;
    logic                    sample_valid;
    logic [2:0]              busy;
    logic                    overrun;

    modport master (
        output trig_shot, trig_hit, trig_march, march_sel, mute, sample_req,
        input  sample, sample_valid, busy, overrun
    );

    modport slave (
        input  trig_shot, trig_hit, trig_march, march_sel, mute, sample_req,
        output sample, sample_valid, busy, overrun
    );
endinterface

// File: rtl/sfx_sample_sequencer.sv
// Three-voice sound effect generator (two square voices, one LFSR noise voice)
// producing one saturated signed PCM sample per request from the I2S stage.
module sfx_sample_sequencer #(
    parameter int          WIDTH      = 16,
    parameter int          AMP        = 4096,
    parameter int          SHOT_HALF  = 24,
    parameter int          SHOT_LEN   = 9600,
    parameter int          HIT_LEN    = 14400,
    parameter int          MARCH_HALF = 60,
    parameter int          MARCH_LEN  = 2400,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    sfx_sample_sequencer_if.slave bus
);
    localparam int MARCH_MAX = MARCH_HALF << 3;
    localparam int MAX_HALF  = (SHOT_HALF > MARCH_MAX) ? SHOT_HALF : MARCH_MAX;
    localparam int MAX_LEN0  = (SHOT_LEN > MARCH_LEN) ? SHOT_LEN : MARCH_LEN;
    localparam int MAX_LEN   = (MAX_LEN0 > HIT_LEN) ? MAX_LEN0 : HIT_LEN;
    localparam int PW        = $clog2(MAX_HALF + 1);
    localparam int LW        = $clog2(MAX_LEN + 1);
    localparam int SW        = WIDTH + 2;

    localparam logic signed [SW-1:0] POS    = SW'(AMP);
    localparam logic signed [SW-1:0] NEG    = -POS;
    localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;
    localparam logic [15:0]          LFSR_MASK = 16'hB400;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ADVANCE = 2'd1;
    localparam logic [1:0] S_MIX     = 2'd2;

    logic [1:0]              r_state;
    logic signed [WIDTH-1:0] r_sample;
    logic                    r_valid;
    logic                    r_overrun;
    logic [PW-1:0]           r_march_half;
    logic                    r_hit_active;
    logic [LW-1:0]           r_hit_remaining;
    logic [15:0]             r_lfsr;

    logic                    w_step;
    logic [1:0]              w_sq_trig;
    logic [1:0]              w_sq_active;
    logic [PW-1:0]           w_half [2];
    logic signed [SW-1:0]    w_sq_contrib [2];
    logic signed [SW-1:0]    w_hit_contrib;
    logic signed [SW-1:0]    w_sum;
    logic [WIDTH-1:0]        w_sat;

    assign w_step    = (r_state == S_ADVANCE);
    assign w_sq_trig = {bus.trig_march, bus.trig_shot};
    assign w_half[0] = PW'(SHOT_HALF);
    assign w_half[1] = r_march_half;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_march_half <= '0;
        end else if (bus.trig_march) begin
            r_march_half <= PW'(MARCH_HALF) << bus.march_sel;
        end
    end

    // Square voices: index 0 is the shot, index 1 the march.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_square
            localparam int LEN_I = (gi == 0) ? SHOT_LEN : MARCH_LEN;

            logic          r_active;
            logic [LW-1:0] r_remaining;
            logic [PW-1:0] r_phase;
            logic          r_level;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_active    <= 1'b0;
                    r_remaining <= '0;
                    r_phase     <= '0;
                    r_level     <= 1'b0;
                end else if (w_sq_trig[gi]) begin
                    r_active    <= 1'b1;
                    r_remaining <= LW'(LEN_I);
                    r_phase     <= '0;
                    r_level     <= 1'b1;
                end else if (w_step && r_active) begin
                    if (r_phase == w_half[gi] - PW'(1)) begin
                        r_phase <= '0;
                        r_level <= ~r_level;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                    r_remaining <= r_remaining - LW'(1);
                    if (r_remaining == LW'(1)) begin
                        r_active <= 1'b0;
                    end
                end
            end

            assign w_sq_active[gi]  = r_active;
            assign w_sq_contrib[gi] = !r_active ? '0 : (r_level ? POS : NEG);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_active    <= 1'b0;
            r_hit_remaining <= '0;
            r_lfsr          <= LFSR_SEED;
        end else if (bus.trig_hit) begin
            r_hit_active    <= 1'b1;
            r_hit_remaining <= LW'(HIT_LEN);
            r_lfsr          <= LFSR_SEED;
        end else if (w_step && r_hit_active) begin
            r_lfsr          <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
            r_hit_remaining <= r_hit_remaining - LW'(1);
            if (r_hit_remaining == LW'(1)) begin
                r_hit_active <= 1'b0;
            end
        end
    end

    assign w_hit_contrib = !r_hit_active ? '0 : (r_lfsr[0] ? POS : NEG);

    always_comb begin
        w_sum = w_sq_contrib[0] + w_sq_contrib[1] + w_hit_contrib;
        if (w_sum > SAT_HI) begin
            w_sat = SAT_HI[WIDTH-1:0];
        end else if (w_sum < SAT_LO) begin
            w_sat = SAT_LO[WIDTH-1:0];
        end else begin
            w_sat = w_sum[WIDTH-1:0];
        end
    end

    // The mix is captured at the end of S_ADVANCE so the sample and its valid
    // pulse are presented throughout S_MIX, two cycles after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.sample_req) begin
                        r_state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    r_sample <= bus.mute ? '0 : w_sat;
                    r_valid  <= 1'b1;
                    r_state  <= S_MIX;
                end
                S_MIX: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (bus.sample_req && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = {w_sq_active[1], r_hit_active, w_sq_active[0]};
    assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_sfx_sample_sequencer.sv
// Directed bench for the sound sequencer: two instances (normal and large
// amplitude) share stimulus; a reference model queues expected samples.
module tb_sfx_sample_sequencer;
    localparam int          W     = 16;
    localparam int          AMP_A = 4096;
    localparam int          AMP_B = 16000;
    localparam int          SH    = 2;
    localparam int          SL    = 6;
    localparam int          HL    = 6;
    localparam int          MH    = 1;
    localparam int          ML    = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sfx_sample_sequencer_if #(.WIDTH(W)) if_a ();
    sfx_sample_sequencer_if #(.WIDTH(W)) if_b ();

    assign if_b.trig_shot  = if_a.trig_shot;
    assign if_b.trig_hit   = if_a.trig_hit;
    assign if_b.trig_march = if_a.trig_march;
    assign if_b.march_sel  = if_a.march_sel;
    assign if_b.mute       = if_a.mute;
    assign if_b.sample_req = if_a.sample_req;

    sfx_sample_sequencer #(
        .WIDTH(W), .AMP(AMP_A), .SHOT_HALF(SH), .SHOT_LEN(SL), .HIT_LEN(HL),
        .MARCH_HALF(MH), .MARCH_LEN(ML), .LFSR_SEED(SEED)
    ) u_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );

    sfx_sample_sequencer #(
        .WIDTH(W), .AMP(AMP_B), .SHOT_HALF(SH), .SHOT_LEN(SL), .HIT_LEN(HL),
        .MARCH_HALF(MH), .MARCH_LEN(ML), .LFSR_SEED(SEED)
    ) u_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );

    int checks = 0;
    int errors = 0;
    logic signed [W-1:0] q_a [$];
    logic signed [W-1:0] q_b [$];

    // Reference model: per-voice sample index since trigger (index >= LEN means idle).
    int          ks, km, kh, mhalf;
    logic [15:0] lfsr;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [W-1:0] sat(input int v);
        int r;
        r = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
        return W'(r);
    endfunction

    function automatic logic [2:0] exp_busy();
        return {km < ML, kh < HL, ks < SL};
    endfunction

    task automatic model_reset();
        ks = SL; km = ML; kh = HL; mhalf = MH; lfsr = SEED;
    endtask

    task automatic model_trig(input logic ts, input logic th, input logic tm,
                              input logic [1:0] sel);
        if (ts) ks = 0;
        if (th) begin kh = 0; lfsr = SEED; end
        if (tm) begin km = 0; mhalf = MH << sel; end
    endtask

    task automatic model_req();
        int u = 0;
        if (ks < SL) begin u += (((ks / SH) % 2) == 0) ? 1 : -1; ks++; end
        if (km < ML) begin u += (((km / mhalf) % 2) == 0) ? 1 : -1; km++; end
        if (kh < HL) begin
            u += lfsr[0] ? 1 : -1;
            lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            kh++;
        end
        q_a.push_back(if_a.mute ? W'(0) : sat(u * AMP_A));
        q_b.push_back(if_a.mute ? W'(0) : sat(u * AMP_B));
    endtask

    always @(negedge clk) begin
        if (if_a.sample_valid === 1'b1) begin
            if (q_a.size() == 0) check("pending_a", 0, 1);
            else check("sample_a", if_a.sample, q_a.pop_front());
            $display("sample_a %0d", if_a.sample);
        end
        if (if_b.sample_valid === 1'b1) begin
            if (q_b.size() == 0) check("pending_b", 0, 1);
            else check("sample_b", if_b.sample, q_b.pop_front());
            $display("sample_b %0d", if_b.sample);
        end
    end

    // One directed step: optional triggers and/or a request, then idle cycles.
    task automatic step(input logic ts, input logic th, input logic tm,
                        input logic [1:0] sel, input logic rq, input int gap);
        logic [2:0] mask;
        mask = {tm, th, ts};
        @(negedge clk);
        if_a.trig_shot  = ts;
        if_a.trig_hit   = th;
        if_a.trig_march = tm;
        if_a.march_sel  = sel;
        if_a.sample_req = rq;
        model_trig(ts, th, tm, sel);
        if (rq) model_req();
        @(negedge clk);
        if_a.trig_shot  = 1'b0;
        if_a.trig_hit   = 1'b0;
        if_a.trig_march = 1'b0;
        if_a.sample_req = 1'b0;
        if (mask != 3'b000) check("busy_trig", if_a.busy & mask, mask);
        if (rq) begin
            check("valid_n1", if_a.sample_valid, 0);
            @(negedge clk);
            check("valid_n2", if_a.sample_valid, 1);
            check("busy", if_a.busy, exp_busy());
            @(negedge clk);
            check("valid_n3", if_a.sample_valid, 0);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rst_sample", if_a.sample, 0);
        check("rst_busy", if_a.busy, 0);
    endtask

    initial begin
        if_a.trig_shot  = 1'b0;
        if_a.trig_hit   = 1'b0;
        if_a.trig_march = 1'b0;
        if_a.march_sel  = 2'd0;
        if_a.mute       = 1'b0;
        if_a.sample_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_sample_a", if_a.sample, 0);
        check("rst_sample_b", if_b.sample, 0);
        check("rst_busy", if_a.busy, 0);
        check("rst_overrun", if_a.overrun, 0);
        check("rst_valid", if_a.sample_valid, 0);

        // Silence: no voices active.
        repeat (5) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0);

        // Shot: +,+,-,-,+,+ then silence; busy[0] tracked by the model.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        repeat (7) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6);
        check("shot_busy_end", if_a.busy[0], 0);

        // All three voices with a coincident request: saturation then 16000.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 0);
        check("sat_b", if_b.sample, 32767);
        check("sat_a", if_a.sample, 12288);
        step(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 0);
        check("noise_low_b", if_b.sample, 16000);

        // March with march_sel=2: four high, four low.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 0);
        check("march_busy_end", if_a.busy[2], 0);

        // Mute keeps voices advancing.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        if_a.mute = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0);
        if_a.mute = 1'b0;
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0);
        check("mute_release", if_a.sample, -4096);

        // Reset during S_ADVANCE: no sample is produced.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        @(negedge clk);
        if_a.sample_req = 1'b1;
        @(negedge clk);
        if_a.sample_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("abort_valid", if_a.sample_valid, 0);
        check("abort_busy", if_a.busy, 0);
        repeat (3) @(negedge clk);

        // Overrun: second request one cycle after the first is dropped.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        @(negedge clk);
        if_a.sample_req = 1'b1;
        model_req();
        @(negedge clk);
        if_a.sample_req = 1'b1;
        @(negedge clk);
        if_a.sample_req = 1'b0;
        check("overrun_set", if_a.overrun, 1);
        repeat (3) @(negedge clk);
        check("overrun_no_extra", if_a.sample_valid, 0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2);
        check("overrun_sticky", if_a.overrun, 1);
        do_reset();
        check("overrun_clear", if_a.overrun, 0);

        repeat (4) @(negedge clk);
        check("final_drain_a", q_a.size(), 0);
        check("final_drain_b", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
